pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_perf_cnt.sv | 22 ++
 rtl/pipe_stage.sv | 105 ++++++++++
 tb/tb_pipe_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage skid-buffer slice: state encoding,
// null payload word and performance counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned PERF_CNT_W = 32;
  localparam logic [63:0] ZERO_WORD  = '0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for the pipe_stage performance statistics;
// cleared only by the asynchronous active-low reset.
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Two-entry (main + skid) pipeline register with a registered in_ready.
// Optional stall/bubble counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W  = 64,
  parameter logic [DATA_W-1:0]   RST_VAL = DATA_W'(ZERO_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              rdy_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  // main_q is reloaded with RST_VAL whenever the stage drains, so it can drive out_data directly
  assign out_data  = main_q;
  assign in_fire   = in_valid && rdy_q;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
      rdy_q  <= 1'b0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
      rdy_q  <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= FULL;
            rdy_q  <= 1'b0;
          end else if (out_fire) begin
            main_q <= RST_VAL;
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            skid_q <= RST_VAL;
            state  <= ONE;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= RST_VAL;
          skid_q <= RST_VAL;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.W(PERF_CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt #(.W(PERF_CNT_W)) u_bubble (
    .clk (clk),
    .rst (rst),
    .inc (!out_valid && out_ready),
    .cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed self-checking bench for pipe_stage: a queue scoreboard models the
// held entries and every step checks in_ready, out_valid and out_data.
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] m_stall;
  logic [31:0] m_bubble;
`endif

  logic [63:0] q[$];
  bit          rdy_exp;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic iv, input logic [63:0] id, input logic ordy, input logic fl);
    bit inf;
    bit outf;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_exp});
    chk("out_valid", {63'd0, out_valid}, (q.size() != 0) ? 64'd1 : 64'd0);
    chk("out_data", out_data, (q.size() != 0) ? q[0] : 64'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
    chk("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, m_bubble});
    if ((q.size() != 0) && !ordy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if ((q.size() == 0) && ordy && (m_bubble != 32'hFFFF_FFFF)) m_bubble++;
`endif
    inf  = iv && rdy_exp;
    outf = (q.size() != 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(id);
    end
    @(posedge clk);
    #1;
    rdy_exp = (q.size() < 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    out_ready = 1'b1;
    flush     = 1'b0;
    #1;
    q.delete();
    rdy_exp = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    m_stall  = '0;
    m_bubble = '0;
`endif
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rdy_exp = 1'b0;
    do_reset();

    // release edge: in_valid high but nothing accepted; in_ready rises after it
    step(1'b1, 64'hBEEF, 1'b1, 1'b0);

    // streaming 0x1..0x8
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // backpressure: A, B fill the stage, C waits
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // flush while FULL with a simultaneous offered payload
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // simultaneous in/out while ONE
    step(1'b1, 64'h5, 1'b0, 1'b0);
    step(1'b1, 64'h6, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // reset with entries held discards them
    step(1'b1, 64'h7, 1'b0, 1'b0);
    step(1'b1, 64'h8, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 64'h9, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 64'h11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    chk("stall_ten", {32'd0, stall_cnt}, 64'd10);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 64'h12, 1'b0, 1'b0);
    force dut.u_stall.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall.cnt;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    chk("stall_sat", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
